// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path.
// Holds the FSM state encoding, the supported opcode values and the ALU
// operation codes, so the controller, the datapath and the bench all use the
// same constants.
package cpu_pkg;

    // Controller states. The numeric values are visible on the debug State port.
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    // Supported opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation codes driven on AluC.
    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode     - 6-bit opcode field of the instruction register
//   is_rtype   - R-type instruction
//   is_lw      - load word
//   is_sw      - store word
//   is_beq     - branch if equal
//   is_addi    - add immediate
//   is_illegal - any opcode not listed above
// Exactly one output is high for any opcode value.
module op_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_rtype,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_addi,
    output logic       is_illegal
);

    // One-hot class decode of the opcode; unlisted values fall into illegal.
    always_comb begin
        is_rtype   = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_addi    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: is_rtype   = 1'b1;
            OP_LW:    is_lw      = 1'b1;
            OP_SW:    is_sw      = 1'b1;
            OP_BEQ:   is_beq     = 1'b1;
            OP_ADDI:  is_addi    = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Control unit for a five-state multicycle CPU (IF, ID, EX, MEM, WB).
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   OpCode    - instruction opcode, stable from ID onward
//   Zero      - ALU zero flag (qualifies the beq PC load)
//   MemReady  - memory access completes this cycle (stalls IF and MEM)
//   PC_En, IR_En, BR_En, EnW, EnR - datapath enables
//   AluC      - ALU operation, Mux1 - write-back source, PC_Src - PC source
//   Illegal   - one-cycle pulse in ID for an unknown opcode
//   State     - current state (debug), Retired - completed instruction count
// Outputs are decoded from the state register, the opcode class and the
// handshake inputs; while rst is high every output except State and
// Retired is forced to 0.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PC_En,
    output logic             IR_En,
    output logic             BR_En,
    output logic [2:0]       AluC,
    output logic             EnW,
    output logic             EnR,
    output logic             Mux1,
    output logic             PC_Src,
    output logic             Illegal,
    output logic [2:0]       State,
    output logic [RET_W-1:0] Retired
);

    state_t           cur_state;
    state_t           nxt_state;
    logic [RET_W-1:0] retired_cnt;
    logic             retire;
    logic             is_rtype;
    logic             is_lw;
    logic             is_sw;
    logic             is_beq;
    logic             is_addi;
    logic             is_illegal;

    op_decode u_op_decode (
        .opcode     (OpCode),
        .is_rtype   (is_rtype),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_beq     (is_beq),
        .is_addi    (is_addi),
        .is_illegal (is_illegal)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_IF;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt_state = ST_IF;
        case (cur_state)
            ST_IF: begin
                if (MemReady) nxt_state = ST_ID;
                else          nxt_state = ST_IF;
            end
            ST_ID: begin
                if (is_illegal) nxt_state = ST_IF;
                else            nxt_state = ST_EX;
            end
            ST_EX: begin
                if (is_lw || is_sw)           nxt_state = ST_MEM;
                else if (is_rtype || is_addi) nxt_state = ST_WB;
                else                          nxt_state = ST_IF;
            end
            ST_MEM: begin
                if (!MemReady) nxt_state = ST_MEM;
                else if (is_lw) nxt_state = ST_WB;
                else            nxt_state = ST_IF;
            end
            ST_WB:   nxt_state = ST_IF;
            default: nxt_state = ST_IF;
        endcase
    end

    // Output decode; everything defaults low and is suppressed during reset.
    always_comb begin
        PC_En   = 1'b0;
        IR_En   = 1'b0;
        BR_En   = 1'b0;
        AluC    = ALU_FUNCT;
        EnW     = 1'b0;
        EnR     = 1'b0;
        Mux1    = 1'b0;
        PC_Src  = 1'b0;
        Illegal = 1'b0;
        if (!rst) begin
            case (cur_state)
                ST_IF: begin
                    EnR   = 1'b1;
                    PC_En = MemReady;
                    IR_En = MemReady;
                end
                ST_ID: begin
                    Illegal = is_illegal;
                end
                ST_EX: begin
                    if (is_rtype)    AluC = ALU_FUNCT;
                    else if (is_beq) AluC = ALU_SUB;
                    else             AluC = ALU_ADD;
                    PC_Src = is_beq;
                    PC_En  = is_beq & Zero;
                end
                ST_MEM: begin
                    EnR = is_lw;
                    // The store commits only in the completing cycle so a
                    // stalled store never writes more than once.
                    EnW = is_sw & MemReady;
                end
                ST_WB: begin
                    BR_En = 1'b1;
                    Mux1  = is_rtype | is_addi;
                end
                default: begin
                    EnR = 1'b0;
                end
            endcase
        end else begin
            EnR = 1'b0;
        end
    end

    // An instruction completes on leaving EX (beq), MEM (sw) or WB.
    always_comb begin
        retire = 1'b0;
        case (cur_state)
            ST_EX:   retire = is_beq;
            ST_MEM:  retire = is_sw & MemReady;
            ST_WB:   retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= {RET_W{1'b0}};
        end else if (retire) begin
            retired_cnt <= retired_cnt + {{(RET_W-1){1'b0}}, 1'b1};
        end else begin
            retired_cnt <= retired_cnt;
        end
    end

    assign State   = cur_state;
    assign Retired = retired_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. An instruction-level model
// expands each opcode into its expected per-cycle output trace and the
// Retired count; directed cases are followed by randomized instructions.
module tb_multicycle_control;

    localparam int RET_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       OpCode;
    logic             Zero;
    logic             MemReady;
    logic             PC_En;
    logic             IR_En;
    logic             BR_En;
    logic [2:0]       AluC;
    logic             EnW;
    logic             EnR;
    logic             Mux1;
    logic             PC_Src;
    logic             Illegal;
    logic [2:0]       State;
    logic [RET_W-1:0] Retired;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_en;
        logic       ir_en;
        logic       br_en;
        logic [2:0] aluc;
        logic       enw;
        logic       enr;
        logic       mux1;
        logic       pc_src;
        logic       illegal;
    } obs_t;

    obs_t             obs_now;
    logic [RET_W-1:0] exp_ret;
    int               total;
    int               bad;

    multicycle_control #(.RET_W(RET_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .OpCode   (OpCode),
        .Zero     (Zero),
        .MemReady (MemReady),
        .PC_En    (PC_En),
        .IR_En    (IR_En),
        .BR_En    (BR_En),
        .AluC     (AluC),
        .EnW      (EnW),
        .EnR      (EnR),
        .Mux1     (Mux1),
        .PC_Src   (PC_Src),
        .Illegal  (Illegal),
        .State    (State),
        .Retired  (Retired)
    );

    assign obs_now = {State, PC_En, IR_En, BR_En, AluC, EnW, EnR, Mux1, PC_Src, Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expand one instruction into its expected cycle trace, drive it, compare.
    task automatic run_instr(input logic [5:0] op, input logic z,
                             input int if_stall, input int mem_stall);
        obs_t q_exp[$];
        logic q_mr[$];
        obs_t e;
        bit   is_r, is_lw, is_sw, is_beq, is_addi, known;
        is_r    = (op == 6'b000000);
        is_lw   = (op == 6'b100011);
        is_sw   = (op == 6'b101011);
        is_beq  = (op == 6'b000100);
        is_addi = (op == 6'b001000);
        known   = is_r || is_lw || is_sw || is_beq || is_addi;
        // fetch, possibly stalled
        for (int i = 0; i < if_stall; i++) begin
            e = '0; e.enr = 1'b1;
            q_exp.push_back(e); q_mr.push_back(1'b0);
        end
        e = '0; e.enr = 1'b1; e.pc_en = 1'b1; e.ir_en = 1'b1;
        q_exp.push_back(e); q_mr.push_back(1'b1);
        // decode
        e = '0; e.st = 3'd1; e.illegal = !known;
        q_exp.push_back(e); q_mr.push_back(1'($urandom_range(1, 0)));
        if (known) begin
            e = '0; e.st = 3'd2;
            e.aluc   = is_r ? 3'b000 : (is_beq ? 3'b010 : 3'b001);
            e.pc_src = is_beq;
            e.pc_en  = is_beq && z;
            q_exp.push_back(e); q_mr.push_back(1'($urandom_range(1, 0)));
            if (is_lw || is_sw) begin
                for (int i = 0; i < mem_stall; i++) begin
                    e = '0; e.st = 3'd3; e.enr = is_lw;
                    q_exp.push_back(e); q_mr.push_back(1'b0);
                end
                e = '0; e.st = 3'd3; e.enr = is_lw; e.enw = is_sw;
                q_exp.push_back(e); q_mr.push_back(1'b1);
            end
            if (is_r || is_addi || is_lw) begin
                e = '0; e.st = 3'd4; e.br_en = 1'b1; e.mux1 = is_r || is_addi;
                q_exp.push_back(e); q_mr.push_back(1'($urandom_range(1, 0)));
            end
        end
        OpCode = op;
        Zero   = z;
        foreach (q_exp[i]) begin
            MemReady = q_mr[i];
            @(negedge clk);
            if (i == 0) check_eq("retired_at_start", 32'(Retired), 32'(exp_ret));
            check_eq($sformatf("op%b_cyc%0d", op, i), 32'(obs_now), 32'(q_exp[i]));
            @(posedge clk);
            #1;
        end
        if (known) exp_ret = exp_ret + 4'd1;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            MemReady = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("reset_outputs", 32'(obs_now), 32'h0);
            check_eq("reset_retired", 32'(Retired), 32'h0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_ret = '0;
    endtask

    initial begin
        obs_t e;
        logic [5:0] ops [5];
        logic [5:0] op;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        OpCode   = 6'b000000;
        Zero     = 1'b0;
        MemReady = 1'b0;
        exp_ret  = '0;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000;

        apply_reset(2);

        // directed instructions
        run_instr(6'b000000, 1'b0, 0, 0);   // R-type: 0,1,2,4
        run_instr(6'b100011, 1'b1, 0, 2);   // lw with two MEM stalls: 7 cycles
        run_instr(6'b000100, 1'b1, 0, 0);   // beq taken
        run_instr(6'b000100, 1'b0, 0, 0);   // beq not taken
        run_instr(6'b101011, 1'b0, 1, 1);   // sw with fetch and MEM stall
        run_instr(6'b001000, 1'b0, 0, 0);   // addi
        run_instr(6'b111111, 1'b0, 0, 0);   // illegal

        // sw aborted by reset during its MEM stall
        OpCode = 6'b101011;
        MemReady = 1'b1;
        @(negedge clk); @(posedge clk); #1;  // IF
        @(negedge clk); @(posedge clk); #1;  // ID
        @(negedge clk); @(posedge clk); #1;  // EX
        MemReady = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        e = '0; e.st = 3'd3;
        check_eq("sw_rst_in_mem", 32'(obs_now), 32'(e));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        e = '0; e.enr = 1'b1;
        check_eq("after_rst_if", 32'(obs_now), 32'(e));
        check_eq("after_rst_enw", 32'(EnW), 32'h0);
        check_eq("after_rst_retired", 32'(Retired), 32'h0);
        @(posedge clk); #1;
        exp_ret = '0;

        // 16 branches wrap the 4-bit counter from 15 back to 0
        for (int i = 0; i < 16; i++) run_instr(6'b000100, 1'($urandom_range(1, 0)), 0, 0);

        // randomized instructions, occasionally an arbitrary opcode
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7, 0) == 0) op = 6'($urandom);
            else                          op = ops[$urandom_range(4, 0)];
            run_instr(op, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)),
                      int'($urandom_range(3, 0)));
        end

        MemReady = 1'b0;
        @(negedge clk);
        check_eq("final_retired", 32'(Retired), 32'(exp_ret));
        check_eq("final_state", 32'(State), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
